// File: rtl/core_run_ctrl.sv
// core_run_ctrl: core reset sequencing, run gating and cycle/retire counting.
// Define RUN_CTRL_INSTRET_EN to build the INSTRET counter; otherwise INSTRET is 0.
module core_run_ctrl #(
  parameter int RST_CYCLES = 6,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 50,
  parameter int AUTO_START = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             HALT_REQ,
  input  logic             RETIRE,
  output logic             CORE_RESET,
  output logic             CORE_EN,
  output logic             RUNNING,
  output logic             DONE,
  output logic             TIMED_OUT,
  output logic [CNT_W-1:0] CYCLE_COUNT,
  output logic [CNT_W-1:0] INSTRET
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;
  localparam logic [1:0] S_RST  = (AUTO_START != 0) ? S_HOLD : S_IDLE;

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             crst_q, crst_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cyc_inc;
  logic             restart;

  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    crst_d  = crst_q;
    run_d   = run_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    cyc_d   = cyc_q;
    restart = 1'b0;
    unique case (state_q)
      S_IDLE: restart = START;
      S_HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          crst_d  = 1'b0;
          run_d   = 1'b1;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        // halt has priority over a timeout landing on the same edge
        if (HALT_REQ) begin
          state_d = S_FIN;
          run_d   = 1'b0;
          done_d  = 1'b1;
          tmo_d   = 1'b0;
        end else if (TIMEOUT != 0 && cyc_inc == TMO) begin
          state_d = S_FIN;
          run_d   = 1'b0;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      S_FIN: restart = START;
      default: state_d = S_RST;
    endcase
    if (restart) begin
      state_d = S_HOLD;
      hold_d  = '0;
      crst_d  = 1'b1;
      run_d   = 1'b0;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      cyc_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_RST;
      hold_q  <= '0;
      crst_q  <= 1'b1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      crst_q  <= crst_d;
      run_q   <= run_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
    end
  end

  assign CORE_RESET  = crst_q;
  assign CORE_EN     = run_q;
  assign RUNNING     = run_q;
  assign DONE        = done_q;
  assign TIMED_OUT   = tmo_q;
  assign CYCLE_COUNT = cyc_q;

`ifdef RUN_CTRL_INSTRET_EN
  logic [CNT_W-1:0] ret_q, ret_d;

  always_comb begin
    ret_d = ret_q;
    if (restart) begin
      ret_d = '0;
    end else if (state_q == S_RUN && RETIRE && !(&ret_q)) begin
      ret_d = ret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end

  assign INSTRET = ret_q;
`else
  logic unused_retire;
  assign unused_retire = RETIRE;
  assign INSTRET       = '0;
`endif

endmodule
